uart_rx_frame: RTL and testbench

- Parametrised UART receiver for streaming image and tensor payloads from the host into the accelerator input buffer.
- Configurable data width, parity and stop bits, with oversampled majority-vote sampling.
- Detects parity, framing, overrun and break errors.
- Buffers bytes in a small FIFO behind a valid/ready output, and counts accepted bytes per payload frame of FRAME_BYTES.

---
 rtl/uart_rx_frame.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: majority-vote bit decisions, parity/framing/overrun/break
// detection, a small output FIFO behind valid/ready and per-frame character counting.
module uart_rx_frame #(
   parameter int CLK_FREQ    = 50000000,
   parameter int BAUD_RATE   = 115200,
   parameter int OVERSAMPLE  = 16,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1,
   parameter int FIFO_DEPTH  = 4,
   parameter int FRAME_BYTES = 150528,
   parameter int CNT_W       = 18
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [CNT_W-1:0]     byte_count,
   output logic                 frame_done,
   output logic                 parity_err,
   output logic                 framing_err,
   output logic                 overrun_err,
   output logic                 break_det,
   input  logic                 clr_err
);

   localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SC_W    = $clog2(OVERSAMPLE);
   localparam int MID     = OVERSAMPLE / 2;
   localparam int BI_W    = $clog2(DATA_BITS);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);

   localparam logic             LAST_STOP = (STOP_BITS == 2);
   localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_BYTES - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_BREAK  = 3'd5;

   // synchroniser and edge detection
   logic       rx_meta;
   logic       rx_sync;
   logic       rx_prev;
   logic [1:0] sync_fill;

   // bit timing
   logic [DIV_W-1:0] div_cnt;
   logic [SC_W-1:0]  sample_cnt;
   logic             tick;
   logic             decide;
   logic             bit_end;
   logic             s_a;
   logic             s_b;
   logic             vote;

   // character FSM
   logic [2:0]           state;
   logic                 armed;
   logic [BI_W-1:0]      bit_idx;
   logic                 stop_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic                 par_bad;
   logic                 frm_bad;
   logic                 exp_par;
   logic                 start_edge;

   // completion decode
   logic is_break;
   logic complete;
   logic stop_bad;
   logic good;

   // FIFO
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W:0]       fill;
   logic                 full;
   logic                 pop;
   logic                 push;
   logic                 overrun;

   // --------------------------------------------------------------------------
   // Input synchroniser. sync_fill marks when rx_sync carries a real line sample
   // rather than the reset preset, so a line held low through reset cannot arm.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: flops use <= so each stage samples the value from before the edge;
      // blocking = would collapse the two-stage chain into a single flop.
      if (rst) begin
         rx_meta   <= 1'b1;
         rx_sync   <= 1'b1;
         rx_prev   <= 1'b1;
         sync_fill <= 2'b00;
      end else begin
         rx_meta   <= rx;
         rx_sync   <= rx_meta;
         rx_prev   <= rx_sync;
         sync_fill <= {sync_fill[0], 1'b1};
      end
   end

   assign start_edge = (state == S_IDLE) && armed && rx_prev && !rx_sync;

   // --------------------------------------------------------------------------
   // Tick divider and per-bit sample counter, both realigned on a start edge.
   // --------------------------------------------------------------------------
   assign tick    = (div_cnt == DIV_W'(DIV - 1));
   assign decide  = tick && (sample_cnt == SC_W'(MID + 1));
   assign bit_end = tick && (sample_cnt == SC_W'(OVERSAMPLE - 1));
   assign vote    = (s_a & s_b) | (s_a & rx_sync) | (s_b & rx_sync);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt    <= '0;
         sample_cnt <= '0;
         s_a        <= 1'b1;
         s_b        <= 1'b1;
      end else if (start_edge) begin
         div_cnt    <= '0;
         sample_cnt <= '0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick && state != S_IDLE && state != S_BREAK) begin
            if (sample_cnt == SC_W'(OVERSAMPLE - 1)) begin
               sample_cnt <= '0;
            end else begin
               sample_cnt <= sample_cnt + 1'b1;
            end
            if (sample_cnt == SC_W'(MID - 1)) s_a <= rx_sync;
            if (sample_cnt == SC_W'(MID))     s_b <= rx_sync;
         end
      end
   end

   assign exp_par = (PARITY == 1) ? ~(^shreg) : ^shreg;

   // --------------------------------------------------------------------------
   // Stop-bit decode: break, completion and whether the character is clean.
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the conditional so no path
      // leaves it unassigned and infers a latch.
      is_break = 1'b0;
      complete = 1'b0;
      stop_bad = 1'b0;
      good     = 1'b0;
      if (state == S_STOP && decide) begin
         stop_bad = frm_bad | ~vote;
         is_break = (stop_idx == 1'b0) && (shreg == '0) && ((PARITY == 0) || !par_bit) && !vote;
         complete = (stop_idx == LAST_STOP) && !is_break;
         good     = complete && !par_bad && !stop_bad;
      end
   end

   // --------------------------------------------------------------------------
   // Character FSM.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         armed    <= 1'b0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         par_bad  <= 1'b0;
         frm_bad  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!armed && sync_fill[1] && rx_sync) armed <= 1'b1;
               if (start_edge) begin
                  state    <= S_START;
                  bit_idx  <= '0;
                  stop_idx <= 1'b0;
                  par_bit  <= 1'b0;
                  par_bad  <= 1'b0;
                  frm_bad  <= 1'b0;
               end
            end
            S_START: begin
               if (decide && vote) begin
                  state <= S_IDLE;
               end else if (bit_end) begin
                  state <= S_DATA;
               end
            end
            S_DATA: begin
               if (decide) shreg <= {vote, shreg[DATA_BITS-1:1]};
               if (bit_end) begin
                  if (bit_idx == BI_W'(DATA_BITS - 1)) begin
                     bit_idx <= '0;
                     state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
            S_PARITY: begin
               if (decide) begin
                  par_bit <= vote;
                  par_bad <= (vote != exp_par);
               end
               if (bit_end) state <= S_STOP;
            end
            S_STOP: begin
               if (is_break) begin
                  state <= S_BREAK;
                  armed <= 1'b0;
               end else if (decide) begin
                  if (!vote) frm_bad <= 1'b1;
                  if (stop_idx == LAST_STOP) state <= S_IDLE;
               end else if (bit_end) begin
                  stop_idx <= stop_idx + 1'b1;
               end
            end
            S_BREAK: begin
               if (rx_sync) begin
                  state <= S_IDLE;
                  armed <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Output FIFO. A pop in the same clock frees a slot for a push into a full FIFO.
   // --------------------------------------------------------------------------
   assign full    = (fill == FIFO_FULL);
   assign pop     = m_valid && m_ready;
   assign push    = good && (!full || pop);
   assign overrun = good && full && !pop;
   assign m_valid = (fill != '0);
   assign m_data  = m_valid ? mem[rd_ptr] : '0;

   // NOTE: storage has no reset; fill and the pointers define which entries are
   // live, and resetting the array would only cost routing and area.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= shreg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: ;
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Frame counter and status flags; a set event wins over clr_err.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_count <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (push) begin
            if (byte_count == LAST_CNT) begin
               byte_count <= '0;
               frame_done <= 1'b1;
            end else begin
               byte_count <= byte_count + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_err  <= 1'b0;
         framing_err <= 1'b0;
         overrun_err <= 1'b0;
         break_det   <= 1'b0;
      end else begin
         break_det <= is_break;

         if (complete && par_bad)                  parity_err <= 1'b1;
         else if (clr_err)                         parity_err <= 1'b0;

         if ((complete && stop_bad) || is_break)   framing_err <= 1'b1;
         else if (clr_err)                         framing_err <= 1'b0;

         if (overrun)                              overrun_err <= 1'b1;
         else if (clr_err)                         overrun_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Randomised scoreboard bench for uart_rx_frame: an 8N1 instance and an 8E1 instance
// driven serially, expectations computed from character-level rules.
module tb_uart_rx_frame;

   localparam int OS = 16;
   localparam int FB = 4;
   localparam int FD = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clr_err = 1'b0;

   logic        rx = 1'b1;
   logic        m_ready = 1'b1;
   logic [7:0]  m_data;
   logic        m_valid;
   logic [17:0] byte_count;
   logic        frame_done, parity_err, framing_err, overrun_err, break_det;

   logic        rx_p = 1'b1;
   logic        mp_ready = 1'b1;
   logic [7:0]  mp_data;
   logic        mp_valid;
   logic [17:0] byte_count_p;
   logic        frame_done_p, parity_err_p, framing_err_p, overrun_err_p, break_det_p;

   always #5 clk = ~clk;

   uart_rx_frame #(
      .CLK_FREQ(16000000), .BAUD_RATE(1000000), .OVERSAMPLE(OS), .DATA_BITS(8),
      .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(FD), .FRAME_BYTES(FB), .CNT_W(18)
   ) dut (
      .clk(clk), .rst(rst), .rx(rx), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .byte_count(byte_count), .frame_done(frame_done), .parity_err(parity_err),
      .framing_err(framing_err), .overrun_err(overrun_err), .break_det(break_det),
      .clr_err(clr_err)
   );

   uart_rx_frame #(
      .CLK_FREQ(16000000), .BAUD_RATE(1000000), .OVERSAMPLE(OS), .DATA_BITS(8),
      .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(FD), .FRAME_BYTES(FB), .CNT_W(18)
   ) dut_p (
      .clk(clk), .rst(rst), .rx(rx_p), .m_data(mp_data), .m_valid(mp_valid), .m_ready(mp_ready),
      .byte_count(byte_count_p), .frame_done(frame_done_p), .parity_err(parity_err_p),
      .framing_err(framing_err_p), .overrun_err(overrun_err_p), .break_det(break_det_p),
      .clr_err(clr_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state, index 0 = 8N1 instance, 1 = 8E1 instance
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   int exp_cnt[2]     = '{0, 0};
   int exp_frames[2]  = '{0, 0};
   int exp_brk[2]     = '{0, 0};
   bit exp_perr[2]    = '{0, 0};
   bit exp_ferr[2]    = '{0, 0};
   bit exp_oerr[2]    = '{0, 0};
   int seen_frames[2] = '{0, 0};
   int seen_brk[2]    = '{0, 0};
   bit rand_done      = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic line(input int p, input logic v);
      if (p == 0) rx = v;
      else        rx_p = v;
   endtask

   function automatic void clear_model_flags();
      for (int i = 0; i < 2; i++) begin
         exp_perr[i] = 1'b0;
         exp_ferr[i] = 1'b0;
         exp_oerr[i] = 1'b0;
      end
   endfunction

   // Character-level expectation: classify by parity/stop rules, then FIFO room.
   function automatic void model_char(input int p, input logic [7:0] d, input logic pb, input logic stop);
      bit brk, par_ok;
      int occ;
      brk = (d == 8'h00) && (p == 0 || pb == 1'b0) && !stop;
      if (brk) begin
         exp_brk[p]++;
         exp_ferr[p] = 1'b1;
         return;
      end
      par_ok = (p == 0) || ((($countones(d) + int'(pb)) % 2) == 0);
      if (!par_ok) exp_perr[p] = 1'b1;
      if (!stop)   exp_ferr[p] = 1'b1;
      if (par_ok && stop) begin
         occ = (p == 0) ? q0.size() : q1.size();
         if (occ >= FD) begin
            exp_oerr[p] = 1'b1;
         end else begin
            if (p == 0) q0.push_back(d);
            else        q1.push_back(d);
            exp_cnt[p] = (exp_cnt[p] + 1) % FB;
            if (exp_cnt[p] == 0) exp_frames[p]++;
         end
      end
   endfunction

   task automatic send_char(input int p, input logic [7:0] d, input logic par_flip, input logic stop);
      logic pb;
      pb = (($countones(d) % 2) == 1) ^ par_flip;
      line(p, 1'b0);
      wait_clk(OS);
      for (int i = 0; i < 8; i++) begin
         line(p, d[i]);
         wait_clk(OS);
      end
      if (p == 1) begin
         line(p, pb);
         wait_clk(OS);
      end
      line(p, stop);
      model_char(p, d, pb, stop);
      wait_clk(OS);
      line(p, 1'b1);
      wait_clk(4);
   endtask

   task automatic check_flags(input int p, input string tag);
      if (p == 0) begin
         check({tag, "_perr"}, parity_err,  exp_perr[0]);
         check({tag, "_ferr"}, framing_err, exp_ferr[0]);
         check({tag, "_oerr"}, overrun_err, exp_oerr[0]);
      end else begin
         check({tag, "_perr_p"}, parity_err_p,  exp_perr[1]);
         check({tag, "_ferr_p"}, framing_err_p, exp_ferr[1]);
         check({tag, "_oerr_p"}, overrun_err_p, exp_oerr[1]);
      end
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      wait_clk(1);
      clr_err = 1'b0;
      clear_model_flags();
      wait_clk(1);
   endtask

   task automatic model_reset();
      q0.delete();
      q1.delete();
      exp_cnt[0] = 0;
      exp_cnt[1] = 0;
      clear_model_flags();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      wait_clk(3);
      rst = 1'b0;
      wait_clk(8);
   endtask

   // Monitor: pops the scoreboard whenever a character is accepted.
   always @(negedge clk) begin
      if (!rst) begin
         if (m_valid && m_ready) begin
            if (q0.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL out0_unexpected: got %0h expected no character", m_data);
            end else begin
               check("out0_data", m_data, q0.pop_front());
            end
         end
         if (mp_valid && mp_ready) begin
            if (q1.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL out1_unexpected: got %0h expected no character", mp_data);
            end else begin
               check("out1_data", mp_data, q1.pop_front());
            end
         end
         if (frame_done)   seen_frames[0]++;
         if (frame_done_p) seen_frames[1]++;
         if (break_det)    seen_brk[0]++;
         if (break_det_p)  seen_brk[1]++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      logic       stop, flip;

      // reset state
      wait_clk(2);
      check("rst_valid", m_valid, 0);
      check("rst_data", m_data, 0);
      check("rst_count", byte_count, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_break", break_det, 0);
      check_flags(0, "rst");
      check("rst_valid_p", mp_valid, 0);
      rst = 1'b0;
      wait_clk(8);

      // 1: 8N1 0xA5; m_valid one clock after the stop decision tick
      fork
         send_char(0, 8'hA5, 1'b0, 1'b1);
         begin
            int n;
            n = 0;
            while (n < 400) begin
               @(posedge clk);
               #1;
               n++;
               if (m_valid) break;
            end
            // 2 sync flops + edge register, 9 bit times, stop decision tick, FIFO write
            check("t1_latency", n, 3 + 9 * OS + (OS / 2 + 1) + 1);
            @(posedge clk);
            #1;
            check("t1_valid_width", m_valid, 0);
         end
      join
      check("t1_count", byte_count, exp_cnt[0]);
      check_flags(0, "t1");

      // 2: even parity, wrong parity bit then correct one
      send_char(1, 8'h03, 1'b1, 1'b1);
      check_flags(1, "t2_bad");
      wait_clk(20);
      check("t2_sticky", parity_err_p, exp_perr[1]);
      pulse_clr();
      check_flags(1, "t2_clr");
      send_char(1, 8'h03, 1'b0, 1'b1);
      wait_clk(4);
      check("t2_count", byte_count_p, exp_cnt[1]);
      check_flags(1, "t2_good");

      // 3: overrun with consumer stalled, frame wrap after the 4th character
      do_reset();
      m_ready = 1'b0;
      for (int v = 8'h10; v <= 8'h14; v++) send_char(0, 8'(v), 1'b0, 1'b1);
      check("t3_count", byte_count, exp_cnt[0]);
      check("t3_frames", seen_frames[0], exp_frames[0]);
      check_flags(0, "t3");
      check("t3_valid", m_valid, 1);
      check("t3_hold", m_data, 8'h10);
      m_ready = 1'b1;
      wait_clk(10);
      check("t3_drained", q0.size(), 0);
      check("t3_empty", m_valid, 0);

      // 4: short low glitch on an idle line, then a real character
      pulse_clr();
      line(0, 1'b0);
      wait_clk(6);
      line(0, 1'b1);
      wait_clk(40);
      check("t4_glitch_valid", m_valid, 0);
      check("t4_glitch_count", byte_count, exp_cnt[0]);
      check_flags(0, "t4_glitch");
      send_char(0, 8'h5A, 1'b0, 1'b1);
      check("t4_count", byte_count, exp_cnt[0]);
      check_flags(0, "t4");

      // 5: line low for 30 bit times -> single break
      line(0, 1'b0);
      wait_clk(30 * OS);
      exp_brk[0]++;
      exp_ferr[0] = 1'b1;
      check("t5_breaks", seen_brk[0], exp_brk[0]);
      check_flags(0, "t5");
      check("t5_valid", m_valid, 0);
      line(0, 1'b1);
      wait_clk(2 * OS);
      send_char(0, 8'h7E, 1'b0, 1'b1);
      check("t5_count", byte_count, exp_cnt[0]);

      // 6: reset in the 4th data bit of 0xFF, line held low through release
      do_reset();
      line(0, 1'b0);
      wait_clk(OS);
      for (int i = 0; i < 3; i++) begin
         line(0, 1'b1);
         wait_clk(OS);
      end
      line(0, 1'b1);
      wait_clk(OS / 2);
      line(0, 1'b0);
      rst = 1'b1;
      model_reset();
      wait_clk(3);
      check("t6_rst_valid", m_valid, 0);
      check("t6_rst_count", byte_count, 0);
      rst = 1'b0;
      wait_clk(12 * OS);
      check("t6_low_valid", m_valid, 0);
      check("t6_low_count", byte_count, exp_cnt[0]);
      check("t6_low_breaks", seen_brk[0], exp_brk[0]);
      check_flags(0, "t6_low");
      line(0, 1'b1);
      wait_clk(2 * OS);
      send_char(0, 8'h33, 1'b0, 1'b1);
      check("t6_count", byte_count, exp_cnt[0]);
      check_flags(0, "t6");

      // random traffic on both instances with a jittery consumer
      do_reset();
      fork
         begin
            for (int k = 0; k < 12; k++) begin
               d = 8'($urandom);
               stop = ($urandom_range(0, 4) != 0) || (d == 8'h00);
               send_char(0, d, 1'b0, stop);
               check("rnd0_count", byte_count, exp_cnt[0]);
               check_flags(0, "rnd0");
            end
            for (int k = 0; k < 12; k++) begin
               d = 8'($urandom);
               flip = ($urandom_range(0, 3) == 0);
               send_char(1, d, flip, 1'b1);
               check("rnd1_count", byte_count_p, exp_cnt[1]);
               check_flags(1, "rnd1");
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               m_ready  = ($urandom_range(0, 3) != 0);
               mp_ready = ($urandom_range(0, 3) != 0);
               wait_clk(1);
            end
         end
      join
      m_ready  = 1'b1;
      mp_ready = 1'b1;
      wait_clk(10);
      check("end_q0", q0.size(), 0);
      check("end_q1", q1.size(), 0);
      check("end_frames0", seen_frames[0], exp_frames[0]);
      check("end_frames1", seen_frames[1], exp_frames[1]);
      check("end_breaks0", seen_brk[0], exp_brk[0]);
      check("end_breaks1", seen_brk[1], exp_brk[1]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
